// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: instruction, register-file, ALU and memory signals of the issue controller
interface alu_issue_ctrl_if;
    logic [31:0] Instr;
    logic        Instr_Valid;
    logic        Instr_Ready;
    logic [3:0]  Rn_Addr;
    logic [3:0]  Rm_Addr;
    logic [31:0] Rn_Data;
    logic [31:0] Rm_Data;
    logic [3:0]  Opcode;
    logic [2:0]  SR_Cont;
    logic [4:0]  SR_Bit;
    logic        S_Out;
    logic [15:0] Immediate;
    logic [31:0] Alu_Out;
    logic [3:0]  Alu_Flags;
    logic        Wr_En;
    logic [3:0]  Wr_Addr;
    logic [31:0] Wr_Data;
    logic        Mem_Req;
    logic        Mem_We;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_WData;
    logic [31:0] Mem_RData;
    logic        Mem_Ack;
    logic [3:0]  Flags;
    logic        Retire;
    logic        Skipped;
    logic        Illegal;

    modport master (
        input  Instr, Instr_Valid, Rn_Data, Rm_Data, Alu_Out, Alu_Flags, Mem_RData, Mem_Ack,
        output Instr_Ready, Rn_Addr, Rm_Addr, Opcode, SR_Cont, SR_Bit, S_Out, Immediate,
               Wr_En, Wr_Addr, Wr_Data, Mem_Req, Mem_We, Mem_Addr, Mem_WData,
               Flags, Retire, Skipped, Illegal
    );

    modport slave (
        output Instr, Instr_Valid, Rn_Data, Rm_Data, Alu_Out, Alu_Flags, Mem_RData, Mem_Ack,
        input  Instr_Ready, Rn_Addr, Rm_Addr, Opcode, SR_Cont, SR_Bit, S_Out, Immediate,
               Wr_En, Wr_Addr, Wr_Data, Mem_Req, Mem_We, Mem_Addr, Mem_WData,
               Flags, Retire, Skipped, Illegal
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: single-instruction issue controller driving an ALU, register file and memory port
module alu_issue_ctrl #(
    parameter bit         COND_EN     = 1'b1,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input logic clk,
    input logic rst,
    alu_issue_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;

    state_t      state, state_nx;
    logic [31:0] ir, res, mem_addr, mem_wdata;
    logic [3:0]  flags, op;
    logic        mem_we, wr, skip, ill;
    logic        is_cmp, is_mem, is_ill, cond_ok;

    // Conditions come in true/inverted pairs: the low bit inverts the base test
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, b;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0:    b = z;
            3'd1:    b = cy;
            3'd2:    b = n;
            3'd3:    b = v;
            3'd4:    b = cy & ~z;
            3'd5:    b = n == v;
            3'd6:    b = ~z & (n == v);
            default: b = 1'b1;
        endcase
        return b ^ c[0];
    endfunction

    assign op      = ir[27:24];
    assign is_cmp  = op == 4'b1000;
    assign is_mem  = op == 4'b1001 || op == 4'b1010;
    assign is_ill  = op > 4'b1010;
    assign cond_ok = !COND_EN || cond_pass(ir[31:28], flags);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state and outputs; ALU fields always reflect the held instruction
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.Instr_Valid ? EXEC : IDLE;
            EXEC:    state_nx = (cond_ok && !is_ill && is_mem) ? MEM : WB;
            MEM:     state_nx = bus.Mem_Ack ? WB : MEM;
            default: state_nx = IDLE;
        endcase
        bus.Instr_Ready = state == IDLE;
        bus.Rn_Addr     = ir[18:15];
        bus.Rm_Addr     = ir[14:11];
        bus.Opcode      = is_cmp ? 4'b0001 : op;
        bus.SR_Cont     = ir[10:8];
        bus.SR_Bit      = ir[7:3];
        bus.S_Out       = ir[23] | is_cmp;
        bus.Immediate   = ir[15:0];
        bus.Wr_En       = state == WB && wr;
        bus.Wr_Addr     = ir[22:19];
        bus.Wr_Data     = res;
        bus.Mem_Req     = state == MEM;
        bus.Mem_We      = mem_we;
        bus.Mem_Addr    = mem_addr;
        bus.Mem_WData   = mem_wdata;
        bus.Flags       = flags;
        bus.Retire      = state == WB;
        bus.Skipped     = state == WB && skip;
        bus.Illegal     = state == WB && ill;
    end

    // Instruction, result, memory and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ir        <= '0;
            res       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            wr        <= 1'b0;
            skip      <= 1'b0;
            ill       <= 1'b0;
            flags     <= RESET_FLAGS;
        end else begin
            case (state)
                IDLE: if (bus.Instr_Valid) begin
                    ir   <= bus.Instr;
                    wr   <= 1'b0;
                    skip <= 1'b0;
                    ill  <= 1'b0;
                end
                EXEC: if (!cond_ok) skip <= 1'b1;
                else if (is_ill) ill <= 1'b1;
                else if (is_mem) begin
                    mem_addr  <= bus.Rn_Data;
                    mem_wdata <= bus.Rm_Data;
                    mem_we    <= op == 4'b1010;
                    wr        <= op == 4'b1001;
                end else begin
                    res <= bus.Alu_Out;
                    wr  <= !is_cmp;
                    if (ir[23] || is_cmp) flags <= bus.Alu_Flags;
                end
                MEM: if (bus.Mem_Ack && !mem_we) res <= bus.Mem_RData;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed checks of the issue controller with and without condition evaluation
module tb_alu_issue_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    logic [31:0] instr = '0, rn_d = '0, rm_d = '0, rdata = '0;
    logic valid = 1'b0, ack = 1'b0;
    int checks = 0, failures = 0;

    int cyc, reqs;
    logic retired, wb_req, m_we, a_wr, a_skip, a_ill, b_wr, b_skip;
    logic [3:0] exec_op, a_waddr, a_flags, b_flags, b_waddr;
    logic exec_s;
    logic [31:0] m_addr, m_wd, a_wdata, b_wdata;

    alu_issue_ctrl_if a_if();
    alu_issue_ctrl_if b_if();

    alu_issue_ctrl #(.COND_EN(1'b1), .RESET_FLAGS(4'b0000)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
    alu_issue_ctrl #(.COND_EN(1'b0), .RESET_FLAGS(4'b0000)) dut_b (.clk(clk), .rst(rst), .bus(b_if));

    always #5 clk = ~clk;

    function automatic logic [35:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [15:0] imm);
        logic [32:0] w;
        logic [31:0] r;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
                  v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd1: begin r = a - b; c = a < b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd2: r = a * b;
            4'd3: r = a | b;
            4'd4: r = a & b;
            4'd5: r = a ^ b;
            4'd6: r = {16'h0, imm};
            4'd7: r = b;
            default: r = '0;
        endcase
        return {r[31], r == 0, c, v, r};
    endfunction

    assign a_if.Instr = instr;       assign b_if.Instr = instr;
    assign a_if.Instr_Valid = valid; assign b_if.Instr_Valid = valid;
    assign a_if.Rn_Data = rn_d;      assign b_if.Rn_Data = rn_d;
    assign a_if.Rm_Data = rm_d;      assign b_if.Rm_Data = rm_d;
    assign a_if.Mem_RData = rdata;   assign b_if.Mem_RData = rdata;
    assign a_if.Mem_Ack = ack;       assign b_if.Mem_Ack = ack;
    assign {a_if.Alu_Flags, a_if.Alu_Out} = alu(a_if.Opcode, a_if.Rn_Data, a_if.Rm_Data, a_if.Immediate);
    assign {b_if.Alu_Flags, b_if.Alu_Out} = alu(b_if.Opcode, b_if.Rn_Data, b_if.Rm_Data, b_if.Immediate);

    function automatic logic [31:0] mk(input logic [3:0] cond, input logic [3:0] op, input logic s,
                                       input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm);
        return {cond, op, s, rd, rn, rm, 11'h0};
    endfunction

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [31:0] ins, input logic [31:0] n, input logic [31:0] m, input int ack_at);
        instr = ins; rn_d = n; rm_d = m; valid = 1'b1;
        reqs = 0; m_addr = 'x; m_wd = 'x; m_we = 1'bx;
        @(posedge clk); #1 valid = 1'b0; cyc = 1;
        exec_op = a_if.Opcode; exec_s = a_if.S_Out;
        while (!a_if.Retire && cyc < 40) begin
            if (a_if.Mem_Req) begin
                reqs++; m_addr = a_if.Mem_Addr; m_we = a_if.Mem_We; m_wd = a_if.Mem_WData;
            end
            ack = a_if.Mem_Req && reqs == ack_at + 1;
            @(posedge clk); #1 ack = 1'b0; cyc++;
        end
        retired = a_if.Retire; wb_req = a_if.Mem_Req;
        a_wr = a_if.Wr_En; a_waddr = a_if.Wr_Addr; a_wdata = a_if.Wr_Data;
        a_skip = a_if.Skipped; a_ill = a_if.Illegal; a_flags = a_if.Flags;
        b_wr = b_if.Wr_En; b_waddr = b_if.Wr_Addr; b_wdata = b_if.Wr_Data;
        b_skip = b_if.Skipped; b_flags = b_if.Flags;
        chk("retire_seen", retired, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic saw;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", a_if.Instr_Ready, 1'b1);
        chk("rst_strobes", {a_if.Wr_En, a_if.Mem_Req, a_if.Retire, a_if.Skipped, a_if.Illegal}, 5'b0);
        chk("rst_flags", a_if.Flags, 4'b0000);
        rst = 1'b0;

        run(mk(4'hE, 4'h0, 1'b1, 4'd3, 4'd1, 4'd2), 32'd5, 32'd3, 0);
        chk("add_latency", cyc, 2);
        chk("add_wr", {a_wr, a_waddr, a_wdata}, {1'b1, 4'd3, 32'd8});
        chk("add_flags", a_flags, 4'b0000);

        run(mk(4'hE, 4'h8, 1'b0, 4'd9, 4'd1, 4'd2), 32'd7, 32'd7, 0);
        chk("cmp_alu_ctl", {exec_op, exec_s}, {4'b0001, 1'b1});
        chk("cmp_nowr", a_wr, 1'b0);
        chk("cmp_flags", a_flags, 4'b0100);

        run(mk(4'h0, 4'h0, 1'b0, 4'd5, 4'd1, 4'd2), 32'd7, 32'd7, 0);
        chk("addeq_exec", {a_skip, a_wr, a_waddr, a_wdata}, {1'b0, 1'b1, 4'd5, 32'd14});
        chk("addeq_flags", a_flags, 4'b0100);

        run(mk(4'h1, 4'h0, 1'b1, 4'd6, 4'd1, 4'd2), 32'd7, 32'd7, 0);
        chk("addne_skip", {a_skip, a_wr}, 2'b10);
        chk("addne_flags", a_flags, 4'b0100);
        chk("b_addne_exec", {b_skip, b_wr, b_waddr, b_wdata}, {1'b0, 1'b1, 4'd6, 32'd14});
        chk("b_addne_flags", b_flags, 4'b0000);

        rdata = 32'hDEADBEEF;
        run(mk(4'hE, 4'h9, 1'b1, 4'd4, 4'd1, 4'd2), 32'h100, 32'h0, 3);
        chk("ldr_req_cycles", reqs, 4);
        chk("ldr_mem", {m_we, m_addr}, {1'b0, 32'h100});
        chk("ldr_latency", cyc, 6);
        chk("ldr_wb_req_low", wb_req, 1'b0);
        chk("ldr_wr", {a_wr, a_waddr, a_wdata}, {1'b1, 4'd4, 32'hDEADBEEF});
        chk("ldr_flags", a_flags, 4'b0100);

        run(mk(4'hE, 4'hA, 1'b0, 4'd0, 4'd1, 4'd2), 32'h200, 32'h55, 0);
        chk("str_req_cycles", reqs, 1);
        chk("str_mem", {m_we, m_addr, m_wd}, {1'b1, 32'h200, 32'h55});
        chk("str_nowr", {a_wr, a_skip, a_ill}, 3'b000);

        instr = mk(4'hE, 4'h9, 1'b0, 4'd4, 4'd1, 4'd2); rn_d = 32'h300; valid = 1'b1;
        @(posedge clk); #1 valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_mem_req", a_if.Mem_Req, 1'b1);
        rst = 1'b1; valid = 1'b1;
        @(posedge clk); #1;
        chk("rst_mem_req", a_if.Mem_Req, 1'b0);
        chk("rst_no_wb", {a_if.Wr_En, a_if.Retire}, 2'b00);
        chk("rst_mid_flags", a_if.Flags, 4'b0000);
        @(posedge clk); #1 rst = 1'b0; valid = 1'b0;
        chk("rst_ready_after", a_if.Instr_Ready, 1'b1);
        saw = 1'b0;
        repeat (3) begin
            @(posedge clk); #1 saw = saw | a_if.Retire | a_if.Wr_En;
        end
        chk("rst_abandon", saw, 1'b0);

        run(mk(4'hE, 4'h8, 1'b0, 4'd0, 4'd1, 4'd2), 32'd7, 32'd7, 0);
        chk("cmp2_flags", {a_flags, b_flags}, 8'b0100_0100);

        run(mk(4'hE, 4'hC, 1'b1, 4'd2, 4'd1, 4'd2), 32'd1, 32'd1, 0);
        chk("illegal", {a_ill, a_wr, a_skip}, 3'b100);
        chk("illegal_flags", a_flags, 4'b0100);

        run(mk(4'hF, 4'h0, 1'b1, 4'd7, 4'd1, 4'd2), 32'hFFFFFFFF, 32'd1, 0);
        chk("nv_skip", {a_skip, a_wr}, 2'b10);
        chk("nv_flags", a_flags, 4'b0100);
        chk("b_nv_exec", {b_skip, b_wr, b_waddr, b_wdata}, {1'b0, 1'b1, 4'd7, 32'd0});
        chk("b_nv_flags", b_flags, 4'b0110);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Instruction issue/sequencing controller that drives the ALU's control inputs (Opcode, SR_Cont, SR_Bit, S, Immediate) and consumes its result and Flags.
- Latches one 32-bit instruction, evaluates the Cond field against an architectural flag register, and executes the instruction.
- Handles CMP, LDR and STR: CMP sets flags only; LDR/STR run a memory handshake. Results are written back to the register file.

Parameters:
- COND_EN, 1: 1 = evaluate the Cond field; 0 = treat every instruction as AL.
- RESET_FLAGS, 4'b0000: flag register value after reset, as {N,Z,C,V}.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- Instr  in  32  instruction word.
- Instr_Valid  in  1  Instr is valid.
- Instr_Ready  out  1  controller can accept an instruction.
- Rn_Addr  out  4  register-file read port A address.
- Rm_Addr  out  4  register-file read port B address.
- Rn_Data  in  32  read port A data; also routed to ALU In1.
- Rm_Data  in  32  read port B data; also routed to ALU In2.
- Opcode  out  4  ALU opcode.
- SR_Cont  out  3  ALU shift/rotate control.
- SR_Bit  out  5  ALU shift amount.
- S_Out  out  1  ALU S input.
- Immediate  out  16  ALU immediate.
- Alu_Out  in  32  ALU result.
- Alu_Flags  in  4  ALU {N,Z,C,V}.
- Wr_En  out  1  register write strobe.
- Wr_Addr  out  4  destination register.
- Wr_Data  out  32  write data.
- Mem_Req  out  1  memory request.
- Mem_We  out  1  1 = store, 0 = load.
- Mem_Addr  out  32  memory address.
- Mem_WData  out  32  store data.
- Mem_RData  in  32  load data.
- Mem_Ack  in  1  memory transfer complete.
- Flags  out  4  architectural {N,Z,C,V}.
- Retire  out  1  one-cycle pulse when an instruction completes.
- Skipped  out  1  with Retire: condition failed.
- Illegal  out  1  with Retire: undefined opcode.

Behaviour:
- Instruction fields:
  - [31:28] Cond, [27:24] Op, [23] S, [22:19] Rd, [18:15] Rn, [14:11] Rm, [10:8] SR_Cont, [7:3] SR_Bit.
  - Immediate = Instr[15:0]; it is used by MOVI only.
- Op encoding:
  - 0000 ADD, 0001 SUB, 0010 MUL, 0011 OR, 0100 AND, 0101 XOR, 0110 MOVI, 0111 MOV.
  - 1000 CMP: drives ALU Opcode 0001 and S_Out=1; no writeback.
  - 1001 LDR Rd,[Rn]. 1010 STR Rm,[Rn].
  - 1011-1111 are illegal.
- Cond encoding:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z.
  - 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL always; 1111 NV never.
- FSM states: IDLE, EXEC, MEM, WB.
- IDLE:
  - Instr_Ready=1.
  - On Instr_Valid, latch Instr into the instruction register and go to EXEC.
- EXEC (one cycle):
  - ALU control, Rn_Addr and Rm_Addr are driven from the instruction register; the ALU settles combinationally.
  - Condition evaluation uses Flags as held at the start of this cycle.
  - Condition fail → WB with Skipped.
  - Illegal Op → WB with Illegal.
  - ALU op or CMP → capture Alu_Out into the result register, go to WB.
  - If S=1 or CMP, Flags ← Alu_Flags at the end of EXEC.
  - LDR/STR → capture Mem_Addr=Rn_Data, Mem_WData=Rm_Data, Mem_We; go to MEM.
- MEM:
  - Mem_Req=1 with Mem_Addr, Mem_WData and Mem_We held stable.
  - Mem_Ack is sampled on every MEM cycle, including the first.
  - On Mem_Ack: LDR captures Mem_RData into the result register; then go to WB. Mem_Req deasserts in the WB cycle.
  - Mem_Ack outside MEM is ignored.
  - There is no timeout.
- WB (one cycle):
  - Retire=1.
  - Wr_En=1 only for an executed ALU op (excluding CMP) or an executed LDR; Wr_Addr=Rd, Wr_Data=result register.
  - Next state IDLE.
- Latency:
  - Accept on cycle 0; EXEC on cycle 1; WB (Retire) on cycle 2.
  - Memory ops: WB follows the ack cycle by one cycle.
- Flags and ALU field outputs:
  - Flags changes only via S/CMP on executed instructions; skipped and illegal instructions leave it unchanged.
  - Flags updated at the end of EXEC are visible in WB.
  - Flags is not updated by LDR/STR even when S=1.
  - Outside EXEC, ALU control outputs hold the instruction register fields (Opcode = Op, CMP mapped to 0001).
- Reset:
  - Values: state=IDLE, Flags=RESET_FLAGS, instruction and result registers cleared.
  - All strobes are 0: Wr_En, Mem_Req, Retire, Skipped, Illegal.
  - Reset at any state, including mid-MEM, abandons the instruction: no write, no Retire, Mem_Req low the cycle after reset is sampled.
  - Instr_Valid is ignored while rst=1.

Test Plan:
1. ADD AL S=1, Rd=3, Rn_Data=5, Rm_Data=3, behavioural ALU → Wr_En in cycle 2 with Wr_Addr=3, Wr_Data=8, Retire=1; Flags=0000.
2. CMP with Rn_Data=7, Rm_Data=7 → no Wr_En, Flags=0100. Then ADDEQ → executes. Then ADDNE → Retire with Skipped=1, no Wr_En, Flags unchanged.
3. LDR Rd=4, Rn_Data=0x100, Mem_Ack 3 cycles after MEM entry, Mem_RData=0xDEADBEEF → Mem_Req high for exactly 4 cycles, Mem_We=0, Mem_Addr=0x100; WB writes R4=0xDEADBEEF.
4. STR with Rn_Data=0x200, Rm_Data=0x55, Mem_Ack high on the first MEM cycle → one Mem_Req cycle with Mem_We=1, Mem_WData=0x55; Retire, no Wr_En.
5. rst asserted during MEM of an LDR → Mem_Req=0 next cycle, no Wr_En, no Retire, Flags=0000, Instr_Ready=1 after rst drops.
6. Op=1100 → Retire with Illegal=1, no write, Flags unchanged. Cond=1111 ADD S=1 → Skipped, no write, Flags unchanged. Repeat with COND_EN=0 → the NV ADD executes.
